nlprg_n: RTL and testbench
==========================

# nlprg_n

Parametrised N-bit nonlinear pseudo-random generator and the successor to the fixed 8-bit generator. It is a Fibonacci LFSR with zero-state insertion, so it visits all 2^N states, including all-zero, once per period. It adds a step enable, synchronous seed load, and a built-in period monitor. The monitor flags each completed period and latches an error if the state returns to its start point at any step count other than 2^N. It sits beside the arithmetic cores as a stimulus/scrambling source and replaces the bench-side counter comparison with an on-chip check.

## Interface
- N, 8, state/output width; legal 3..32
- TAPS, 8'hB8, N-bit feedback tap mask; bit N-1 must be set; must encode a primitive polynomial (default x^8+x^6+x^5+x^4+1)
- SEED, 0, N-bit start state loaded on reset
- ck  in  1  clock, rising edge
- rst  in  1  reset: asynchronous, active-high
- en  in  1  advance generator one step this cycle
- ld  in  1  synchronous load of seed; priority over en
- seed  in  N  load value for state and monitor start point
- o  out  N  current generator state (registered)
- wrap  out  1  one-cycle pulse: state has just returned to start point
- err  out  1  sticky: period violation detected

## Operation
- Internal registers:
  - s[N-1:0]: state, driven directly on o
  - start[N-1:0]: monitor reference
  - cnt[N-1:0]: steps since the last reset or load, modulo 2^N
- Next-state function: nx = {s[N-2:0], fb}, where fb = (^(s & TAPS)) ^ (s[N-2:0] == 0).
  - The zero term splices 0 into the sequence: 100..0 -> 000..0 -> 000..01.
- Per-edge priority (highest first):
  - rst asserted: s = SEED, start = SEED, cnt = 0, wrap = 0, err = 0. All outputs take these values asynchronously.
  - ld = 1: s <= seed, start <= seed, cnt <= 0, wrap <= 0, err <= 0. en is ignored that cycle.
  - en = 1: s <= nx, cnt <= cnt + 1 (wraps at 2^N), wrap <= (nx == start).
    - err <= err | ((nx == start) != (cnt + 1 == 0)).
    - The comparison uses an N-bit truncated sum.
  - en = 0: s, cnt, start and err hold; wrap <= 0.
- wrap pulses every period with legal TAPS. It also pulses on an early return with illegal TAPS, with err set on the same edge.
- err is cleared only by rst or ld.
- A state sequence that never returns to start (non-maximal TAPS with an off-cycle seed) sets err when cnt wraps to 0.

## Timing
- Latency: o shows nx on the edge where en is sampled high. There is no pipeline.
- wrap and err update on the same edge as the step that causes them.
- en is honoured every cycle, with no throughput limit. Back-to-back wrap pulses are impossible for N ≥ 3 with legal TAPS.
- A load takes effect on the edge where ld is sampled. On the next en, o shows next(seed).
- Reset mid-run: all state is discarded immediately, and the first step after release yields next(SEED).
- The critical path is the N-input zero detect, the tap XOR, and the N-bit compare against start. No extra registers may be added to it; single-cycle behaviour is required.

## Test plan
- N=8 default, rst then en held high: o = 0 after 256 steps.
  - wrap pulses exactly on step 256 and step 512; err stays 0.
  - Every value 0..255 appears exactly once per period, checked with a scoreboard.
- N=4, TAPS=4'hC, SEED=0: o sequence 0,1,2,4,9,3,...
  - After 16 steps o = 0 and wrap = 1; err = 0.
- N=4, TAPS=4'hF (illegal), SEED=0: o sequence 0,1,3,6,12,8,0.
  - On step 6 wrap = 1 and err = 1; err stays 1 afterwards.
- N=8: en toggles 1/0 every other cycle.
  - o changes only on cycles where en is high.
  - wrap occurs after 256 enabled steps, which is 512 cycles.
- N=8: after 37 steps, pulse ld with seed = 8'hA5 while en = 1.
  - o = 8'hA5 and cnt = 0.
  - Exactly 256 further steps later o = 8'hA5 and wrap = 1; err = 0.
- Assert rst asynchronously mid-cycle during a run: o = SEED, wrap = 0 and err = 0 immediately, without waiting for a clock edge.
  - After release, the sequence restarts from next(SEED).

Source files
------------

// File: rtl/nlprg_n.sv
// N-bit nonlinear pseudo-random generator: Fibonacci LFSR with zero-state insertion,
// step enable, synchronous seed load and an on-chip period monitor.
module nlprg_n #(
  parameter int unsigned    N    = 8,
  parameter logic [N-1:0]   TAPS = 8'hB8,
  parameter logic [N-1:0]   SEED = '0
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         en,
  input  logic         ld,
  input  logic [N-1:0] seed,
  output logic [N-1:0] o,
  output logic         wrap,
  output logic         err
);

  logic [N-1:0] s;
  logic [N-1:0] start;
  logic [N-1:0] cnt;
  logic [N-1:0] nx;
  logic [N-1:0] cnt_inc;
  logic         fb;
  logic         hit;
  logic         cnt_zero;

  // Zero term splices 0 between 100..0 and 000..01 so all 2^N states are visited.
  always_comb begin
    fb       = (^(s & TAPS)) ^ (s[N-2:0] == '0);
    nx       = {s[N-2:0], fb};
    cnt_inc  = cnt + N'(1);
    hit      = (nx == start);
    cnt_zero = (cnt_inc == '0);
  end

  // Return to start must coincide with the step count wrapping to zero, otherwise latch err.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      s     <= SEED;
      start <= SEED;
      cnt   <= '0;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else if (ld) begin
      s     <= seed;
      start <= seed;
      cnt   <= '0;
      wrap  <= 1'b0;
      err   <= 1'b0;
    end else if (en) begin
      s     <= nx;
      cnt   <= cnt_inc;
      wrap  <= hit;
      err   <= err | (hit != cnt_zero);
    end else begin
      wrap  <= 1'b0;
    end
  end

  assign o = s;

endmodule

// File: tb/tb_nlprg_n.sv
// Scoreboard bench for nlprg_n: stimulus pushes expected outputs per clock,
// a negedge monitor pops and compares. Covers N=8 default, N=4 legal and illegal taps.
module tb_nlprg_n;

  logic       ck   = 1'b0;
  logic       rst  = 1'b0;
  logic       en   = 1'b0;
  logic       ld   = 1'b0;
  logic [7:0] seed = 8'h00;

  logic [7:0] o8;
  logic       w8, e8;
  logic [3:0] o4c, o4f;
  logic       w4c, e4c, w4f, e4f;

  always #5 ck = ~ck;

  nlprg_n #(.N(8), .TAPS(8'hB8), .SEED(8'h00)) u8 (
    .ck(ck), .rst(rst), .en(en), .ld(ld), .seed(seed), .o(o8), .wrap(w8), .err(e8)
  );
  nlprg_n #(.N(4), .TAPS(4'hC), .SEED(4'h0)) u4c (
    .ck(ck), .rst(rst), .en(en), .ld(ld), .seed(seed[3:0]), .o(o4c), .wrap(w4c), .err(e4c)
  );
  nlprg_n #(.N(4), .TAPS(4'hF), .SEED(4'h0)) u4f (
    .ck(ck), .rst(rst), .en(en), .ld(ld), .seed(seed[3:0]), .o(o4f), .wrap(w4f), .err(e4f)
  );

  typedef struct {
    logic [7:0] o;
    logic       wrap;
    logic       err;
    logic       cov;
  } exp_t;

  exp_t q8[$];
  exp_t q4c[$];
  exp_t q4f[$];

  int total = 0;
  int bad   = 0;
  int hist[256];

  // Hand-derived sequences from state 0
  logic [3:0] seq4c[16] = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                            4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8, 4'd0};
  logic [3:0] seq4f[6]  = '{4'd1, 4'd3, 4'd6, 4'd12, 4'd8, 4'd0};

  logic [7:0] ms;
  int         k8;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [7:0] nx8(input logic [7:0] s);
    logic fb;
    fb = (^(s & 8'hB8)) ^ (s[6:0] == 7'd0);
    return {s[6:0], fb};
  endfunction

  // Drive one clock of stimulus and push the u8 expectation for that edge.
  task automatic step(input logic e, input logic l, input logic [7:0] sd, input logic cov);
    logic w;
    en = e; ld = l; seed = sd;
    @(posedge ck);
    w = 1'b0;
    if (l) begin
      ms = sd; k8 = 0;
    end else if (e) begin
      ms = nx8(ms); k8++;
      w = ((k8 % 256) == 0);
    end
    q8.push_back('{ms, w, 1'b0, cov});
    #1;
  endtask

  task automatic do_reset();
    @(negedge ck);
    #1;
    rst = 1'b1; en = 1'b0; ld = 1'b0;
    #2;
    rst = 1'b0;
    ms = 8'h00; k8 = 0;
  endtask

  always @(negedge ck) begin
    exp_t e;
    if (q8.size() > 0) begin
      e = q8.pop_front();
      chk("u8.o", 32'(o8), 32'(e.o));
      chk("u8.wrap", 32'(w8), 32'(e.wrap));
      chk("u8.err", 32'(e8), 32'(e.err));
      if (e.cov) hist[o8]++;
    end
    if (q4c.size() > 0) begin
      e = q4c.pop_front();
      chk("u4c.o", 32'(o4c), 32'(e.o));
      chk("u4c.wrap", 32'(w4c), 32'(e.wrap));
      chk("u4c.err", 32'(e4c), 32'(e.err));
    end
    if (q4f.size() > 0) begin
      e = q4f.pop_front();
      chk("u4f.o", 32'(o4f), 32'(e.o));
      chk("u4f.wrap", 32'(w4f), 32'(e.wrap));
      chk("u4f.err", 32'(e4f), 32'(e.err));
    end
  end

  initial begin
    int ones;
    for (int v = 0; v < 256; v++) hist[v] = 0;

    #1 rst = 1'b1;
    #1;
    chk("rst.u8.o", 32'(o8), 32'h0);
    chk("rst.u8.wrap", 32'(w8), 32'h0);
    chk("rst.u8.err", 32'(e8), 32'h0);
    chk("rst.u4f.o", 32'(o4f), 32'h0);
    @(negedge ck);
    rst = 1'b0;
    ms = 8'h00; k8 = 0;

    // Free run: two full N=8 periods, legal and illegal N=4 taps alongside
    for (int i = 1; i <= 512; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'(i <= 256));
      if (i <= 32)
        q4c.push_back('{8'(seq4c[(i-1)%16]), 1'((i % 16) == 0), 1'b0, 1'b0});
      if (i <= 12)
        q4f.push_back('{8'(seq4f[(i-1)%6]), 1'((i % 6) == 0), 1'(i >= 6), 1'b0});
    end

    // Mid-cycle async reset while u8 wrap and u4f err are high
    @(negedge ck);
    #1;
    ones = 0;
    for (int v = 0; v < 256; v++) if (hist[v] == 1) ones++;
    chk("cover.once_per_period", 32'(ones), 32'd256);
    chk("pre.u8.wrap", 32'(w8), 32'h1);
    chk("pre.u4f.err_sticky", 32'(e4f), 32'h1);
    chk("pre.u4f.o", 32'(o4f), 32'h3);
    rst = 1'b1;
    #1;
    chk("arst.u8.o", 32'(o8), 32'h0);
    chk("arst.u8.wrap", 32'(w8), 32'h0);
    chk("arst.u8.err", 32'(e8), 32'h0);
    chk("arst.u4f.o", 32'(o4f), 32'h0);
    chk("arst.u4f.err", 32'(e4f), 32'h0);
    en = 1'b0;
    @(negedge ck);
    rst = 1'b0;
    ms = 8'h00; k8 = 0;
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      q4c.push_back('{8'(seq4c[i-1]), 1'b0, 1'b0, 1'b0});
      q4f.push_back('{8'(seq4f[i-1]), 1'b0, 1'b0, 1'b0});
    end

    // en toggling: 256 enabled steps take 512 cycles
    do_reset();
    for (int i = 0; i < 512; i++) step(1'((i % 2) == 0), 1'b0, 8'h00, 1'b0);

    // Load mid-run with en high; full period from the loaded seed
    do_reset();
    for (int i = 0; i < 37; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'hA5, 1'b0);
    chk("ld.u8.o", 32'(o8), 32'hA5);
    chk("ld.u8.cnt", 32'(u8.cnt), 32'h0);
    for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("ld.period.o", 32'(o8), 32'hA5);
    chk("ld.period.wrap", 32'(w8), 32'h1);
    chk("ld.period.err", 32'(e8), 32'h0);

    en = 1'b0;
    @(negedge ck);
    #1;
    chk("queues.drained", 32'(q8.size() + q4c.size() + q4f.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
